load_counter_scheduler: RTL and testbench

LOAD_COUNTER_SCHEDULER -- requirements
Module: load_counter_scheduler

---
 rtl/load_counter_scheduler_pkg.sv | 16 +
 rtl/load_counter_scheduler_rr_arbiter.sv | 36 +++
 rtl/load_counter_scheduler.sv | 135 +++++++++++++
 tb/tb_load_counter_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/load_counter_scheduler_pkg.sv
// Shared definitions for the load counter scheduler: FSM state encoding
// and default sizing constants.
// Latency: n/a (definitions only). Backpressure: n/a.
package load_counter_scheduler_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/load_counter_scheduler_rr_arbiter.sv
// Round-robin selector: the first requester at or after ptr (wrapping) wins.
// Latency: purely combinational, 0 cycles. Backpressure: none; gnt is all-zero when req is zero.
// Ports: req (request vector), ptr (search start index), gnt (one-hot winner), idx (encoded winner).
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  always_comb begin : search
    int         cand;
    logic       found;
    logic [IDX_W-1:0] cand_idx;
    gnt      = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      // cand < N guards against an out-of-range ptr on non-power-of-two N.
      if (!found && (cand < N) && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/load_counter_scheduler.sv
// Time-shares one up-counter among N_REQ requesters: grant, load start value, count to all-ones, pulse done.
// Latency: grant to done = 1 LOAD cycle + (2^CNT_W - start value) RUN cycles, then 1 DONE cycle and 1 IDLE cycle.
// Backpressure: a requester holds req_i high for its slot; dropping it during RUN abandons the slot without done.
// Ports: req_i/val_i per-requester request and start value; grant_o one-hot owner; done_o completion pulse;
//        busy_o high outside IDLE; count_o shared counter value.
module load_counter_scheduler
  import load_counter_scheduler_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*CNT_W-1:0] val_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o,
  output logic [CNT_W-1:0]       count_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   val_q;
  logic [CNT_W-1:0]   count_q;

  logic [N_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [CNT_W-1:0]   val_arr [N_REQ];
  logic [N_REQ-1:0]   owner_onehot;
  logic [IDX_W-1:0]   owner_next;

  // Datapath enables produced by the FSM.
  logic               capture;
  logic               load_cnt;
  logic               inc_cnt;
  logic               adv_ptr;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign arb_any = |arb_gnt;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      val_arr[k] = val_i[k*CNT_W +: CNT_W];
    end
  end

  assign owner_onehot = N_REQ'(1) << owner_q;
  assign owner_next   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    load_cnt = 1'b0;
    inc_cnt  = 1'b0;
    adv_ptr  = 1'b0;
    grant_o  = '0;
    done_o   = '0;
    busy_o   = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (arb_any) begin
          capture = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // The owner's request is not looked at here; abort checking begins in RUN.
        grant_o  = owner_onehot;
        load_cnt = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        grant_o = owner_onehot;
        if (!req_i[owner_q]) begin
          // Abort wins over reaching all-ones in the same cycle.
          adv_ptr = 1'b1;
          state_d = IDLE;
        end else if (count_q == '1) begin
          state_d = DONE;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      DONE: begin
        grant_o = owner_onehot;
        done_o  = owner_onehot;
        adv_ptr = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= '0;
      ptr_q   <= '0;
      val_q   <= '0;
      count_q <= '0;
    end else begin
      if (capture) begin
        owner_q <= arb_idx;
        val_q   <= val_arr[arb_idx];
      end
      if (load_cnt)     count_q <= val_q;
      else if (inc_cnt) count_q <= count_q + CNT_W'(1);
      if (adv_ptr) ptr_q <= owner_next;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_load_counter_scheduler.sv
// Self-checking bench for load_counter_scheduler: directed scenarios plus random traffic
// compared cycle by cycle against a slot-timeline reference model.
// Ports: none (top-level bench).
module tb_load_counter_scheduler;

  localparam int N     = 4;
  localparam int W     = 4;
  localparam int SPAN  = 1 << W;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_i;
  logic [N*W-1:0]   val_i;
  logic [N-1:0]     grant_o;
  logic [N-1:0]     done_o;
  logic             busy_o;
  logic [W-1:0]     count_o;

  always #5 clk = ~clk;

  load_counter_scheduler #(
    .N_REQ (N),
    .CNT_W (W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req_i),
    .val_i   (val_i),
    .grant_o (grant_o),
    .done_o  (done_o),
    .busy_o  (busy_o),
    .count_o (count_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a slot is described by its owner, start value and the
  // number of cycles elapsed since the grant decision (0 = load cycle,
  // 1..run_len = counting cycles, run_len+1 = completion cycle).
  bit m_busy;
  int m_owner, m_val, m_t, m_ptr, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int run_len(input int v);
    return SPAN - v;
  endfunction

  function automatic bit bit_of(input logic [N-1:0] r, input int k);
    return ((r >> k) & 1) != 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_val = 0; m_t = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic check_outputs();
    int exp_grant, exp_done;
    exp_grant = m_busy ? (1 << m_owner) : 0;
    exp_done  = (m_busy && m_t == run_len(m_val) + 1) ? (1 << m_owner) : 0;
    check("grant", 32'(grant_o), 32'(exp_grant));
    check("done",  32'(done_o),  32'(exp_done));
    check("busy",  32'(busy_o),  32'(m_busy));
    check("count", 32'(count_o), 32'(m_cnt));
  endtask

  task automatic model_advance(input logic [N-1:0] r, input logic [N*W-1:0] v);
    bit found;
    int c;
    if (!m_busy) begin
      if (r != '0) begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          c = (m_ptr + i) % N;
          if (!found && bit_of(r, c)) begin
            found   = 1;
            m_owner = c;
          end
        end
        m_val  = int'(v[m_owner*W +: W]);
        m_busy = 1;
        m_t    = 0;
      end
    end else if (m_t == 0) begin
      m_cnt = m_val;
      m_t   = 1;
    end else if (m_t <= run_len(m_val)) begin
      if (!bit_of(r, m_owner)) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end else begin
        if (m_t < run_len(m_val)) m_cnt = m_cnt + 1;
        m_t++;
      end
    end else begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % N;
    end
  endtask

  // Called at a falling edge: check current outputs, apply inputs for the next rising edge.
  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] v);
    check_outputs();
    req_i = r;
    val_i = v;
    model_advance(r, v);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_steps(input logic [N-1:0] r, input logic [N*W-1:0] v, input int n);
    for (int i = 0; i < n; i++) step(r, v);
  endtask

  logic [N-1:0]   rr;
  logic [N*W-1:0] rv;
  bit             hit;
  int             sel;

  initial begin
    reset = 1'b1;
    req_i = '0;
    val_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Single request, start value C: LOAD, four RUN cycles, DONE, then idle.
    run_steps(4'b0001, 16'h000C, 7);
    run_steps(4'b0000, 16'h000C, 3);

    // Boundary start values.
    run_steps(4'b0001, 16'h000F, 4);
    run_steps(4'b0000, 16'h0000, 2);
    run_steps(4'b0001, 16'h0000, 19);
    run_steps(4'b0000, 16'h0000, 3);

    // Fairness with everyone requesting continuously.
    run_steps(4'b1111, 16'hFEDC, 40);
    run_steps(4'b0000, 16'h0000, 2);

    // Abort: owner 2 with start 8 drops its request in its third RUN cycle.
    run_steps(4'b0100, 16'h0800, 4);
    run_steps(4'b1000, 16'h3000, 12);
    run_steps(4'b0000, 16'h0000, 2);

    // Request dropped only during LOAD, start value changed during RUN.
    step(4'b0001, 16'h000A);
    step(4'b0000, 16'h000A);
    run_steps(4'b0001, 16'h0003, 10);
    run_steps(4'b0000, 16'h0000, 3);

    // Reset while counting at 9.
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (m_busy && m_t >= 1 && m_t <= run_len(m_val) && m_cnt == 9) hit = 1;
      else step(4'b0001, 16'h0005);
    end
    check("reach_cnt9", 32'(hit), 32'd1);
    check_outputs();
    reset = 1'b1;
    #1;
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_done",  32'(done_o),  32'd0);
    check("rst_busy",  32'(busy_o),  32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    run_steps(4'b0010, 16'h00E0, 6);
    run_steps(4'b0000, 16'h0000, 2);

    // Random traffic: requests rise and occasionally drop, values churn every cycle.
    rr = '0;
    rv = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (bit_of(rr, i)) begin
          if ($urandom_range(23) == 0) rr = rr ^ (N'(1) << i);
        end else begin
          if ($urandom_range(3) == 0) rr = rr ^ (N'(1) << i);
        end
        sel = int'($urandom_range(3));
        if (sel == 0)      rv[i*W +: W] = '0;
        else if (sel == 1) rv[i*W +: W] = '1;
        else               rv[i*W +: W] = W'($urandom);
      end
      step(rr, rv);
    end

    check_outputs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
